// File: rtl/debug_tx_pkg.sv
// rtl/debug_tx_pkg.sv - state encoding, constants and helpers shared by the debug tx arbiter
package debug_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEPT    = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        FLUSH     = 3'd5
    } tx_arb_state_t;

    localparam logic [7:0] NEWLINE_BYTE = 8'h0A;

    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/debug_tx_arbiter_rr_pick.sv
// rtl/debug_tx_arbiter_rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick
    import debug_tx_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    int idx;

    always_comb begin
        pick = '0;
        idx  = 0;
        // Walk from the farthest offset to the nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        pick_idx = IDX_W'(onehot_to_index(8'(pick)));
    end

endmodule

// File: rtl/debug_tx_arbiter.sv
// rtl/debug_tx_arbiter.sv - message-level round-robin sharing of the debug uart_tx
// Optional stall timeout with newline flush: DEBUG_TX_ARB_TIMEOUT_EN
module debug_tx_arbiter
    import debug_tx_pkg::*;
#(
    parameter int NUM_REQ          = 3,
    parameter int BUSY_WAIT_CYCLES = 3,
    parameter int TIMEOUT_TICKS    = 22000000
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 grant_active,
    output logic                 timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BW_W  = $clog2(BUSY_WAIT_CYCLES + 1);

    tx_arb_state_t      state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic               last_flag;
    logic [BW_W-1:0]    busy_cnt;
    logic               g_valid;
    logic               to_hit;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .pick    (pick),
        .pick_idx(pick_idx)
    );

    assign g_valid      = |(req_valid & grant);
    assign req_ready    = (state == ACCEPT) ? grant : '0;
    assign tx_start     = (state == START) && !tx_busy;
    assign grant_active = |grant;

`ifdef DEBUG_TX_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_TICKS) > 0) ? $clog2(TIMEOUT_TICKS) : 1;
    logic [TO_W-1:0] to_cnt;

    assign to_hit        = (state == ACCEPT) && !g_valid && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
    assign timeout_pulse = (state == FLUSH);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == ACCEPT && !g_valid && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            g_idx     <= '0;
            ptr       <= '0;
            tx_data   <= '0;
            last_flag <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        g_idx <= pick_idx;
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (g_valid) begin
                        tx_data   <= req_data[8*g_idx +: 8];
                        last_flag <= req_last[g_idx];
                        state     <= START;
                    end else if (to_hit) begin
                        state <= FLUSH;
                    end
                end
                // A frame still running from before reset keeps us here.
                START: begin
                    if (!tx_busy) begin
                        busy_cnt <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy || busy_cnt == BW_W'(BUSY_WAIT_CYCLES - 1)) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_flag) begin
                            grant <= '0;
                            ptr   <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                end
`ifdef DEBUG_TX_ARB_TIMEOUT_EN
                FLUSH: begin
                    tx_data   <= NEWLINE_BYTE;
                    last_flag <= 1'b1;
                    state     <= START;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// tb/tb_debug_tx_arbiter.sv - self-checking bench for debug_tx_arbiter
module tb_debug_tx_arbiter;

    localparam int N     = 3;
    localparam int FRAME = 8;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic           grant_active;
    logic           timeout_pulse;

    debug_tx_arbiter #(
        .NUM_REQ         (N),
        .BUSY_WAIT_CYCLES(3),
        .TIMEOUT_TICKS   (16)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .grant        (grant),
        .grant_active (grant_active),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        int         src;
    } exp_t;

    typedef struct {
        logic [N-1:0] mask;
        int           len;
        int           o0;
        int           o1;
        int           o2;
    } vec_t;

    exp_t       exp_q[$];
    logic [8:0] rq[N][$];
    vec_t       vecs[8];
    int         n_checks    = 0;
    int         n_fail      = 0;
    int         starts_seen = 0;
    int         pulses_seen = 0;
    int         stall_cnt   = 0;
    bit         uart_auto   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int src, input int j);
        return 8'h40 + 8'(16 * src + j + 1);
    endfunction

    task automatic push_msg(input int src, input int len, input int off);
        for (int j = 0; j < len; j++) begin
            rq[src].push_back({(j == len - 1), byte_of(src, off + j)});
        end
    endtask

    task automatic expect_msg(input int src, input int len, input int off);
        exp_t e;
        for (int j = 0; j < len; j++) begin
            e.data = byte_of(src, off + j);
            e.src  = src;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (exp_q.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((!all_empty() || grant != '0 || tx_busy) && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
        end
        check({name, "_drain_in_time"}, (cyc < 2000), 1);
    endtask

    // Requester sources and a uart_tx model with a fixed frame length.
    initial begin
        logic [N-1:0] xfer;
        bit           start_seen;
        int           uart_left;
        xfer       = '0;
        start_seen = 1'b0;
        uart_left  = 0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tx_busy    = 1'b0;
        forever begin
            @(negedge clk_in);
            xfer = req_valid & req_ready;
            if (tx_start) start_seen = 1'b1;
            @(posedge clk_in);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            if (uart_auto) begin
                if (start_seen) uart_left = FRAME;
                if (uart_left > 0) begin
                    tx_busy = 1'b1;
                    uart_left--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
            start_seen = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]       = rq[i][0][8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard pop on every start plus per-cycle invariants.
    initial begin
        exp_t       e;
        logic [7:0] held;
        bit         chk;
        bit         seen_busy;
        chk       = 1'b0;
        seen_busy = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk_in);
            if (!reset) chk = 1'b0;
            check("grant_active", grant_active, |grant);
            check("grant_onehot0", $onehot0(grant), 1);
            check("ready_within_grant", req_ready & ~grant, 0);
            if (req_ready[1] && !req_valid[1]) stall_cnt++;
`ifdef DEBUG_TX_ARB_TIMEOUT_EN
            if (timeout_pulse) begin
                pulses_seen++;
                check("stall_cycles_before_timeout", stall_cnt, 16);
            end
`else
            check("timeout_pulse_off", timeout_pulse, 0);
`endif
            if (chk) begin
                check("tx_data_stable", tx_data, held);
                if (tx_busy) seen_busy = 1'b1;
                else if (seen_busy) chk = 1'b0;
            end
            if (tx_start) begin
                starts_seen++;
                check("start_while_not_busy", tx_busy, 0);
                check("start_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("start_data", tx_data, e.data);
                    check("start_grant", grant, 1 << e.src);
                end
                held      = tx_data;
                chk       = 1'b1;
                seen_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int cyc;
        reset = 1'b0;
        // Orders are hand-derived from the pointer left by the previous row.
        vecs[0] = '{3'b111, 2, 0, 1, 2};
        vecs[1] = '{3'b101, 2, 0, 2, -1};
        vecs[2] = '{3'b001, 2, 0, -1, -1};
        vecs[3] = '{3'b011, 1, 1, 0, -1};
        vecs[4] = '{3'b110, 3, 1, 2, -1};
        vecs[5] = '{3'b100, 1, 2, -1, -1};
        vecs[6] = '{3'b010, 2, 1, -1, -1};
        vecs[7] = '{3'b100, 1, 2, -1, -1};

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_grant", grant, 0);
        check("rst_grant_active", grant_active, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_timeout_pulse", timeout_pulse, 0);
        reset = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk_in);
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) push_msg(i, vecs[v].len, 0);
            end
            if (vecs[v].o0 >= 0) expect_msg(vecs[v].o0, vecs[v].len, 0);
            if (vecs[v].o1 >= 0) expect_msg(vecs[v].o1, vecs[v].len, 0);
            if (vecs[v].o2 >= 0) expect_msg(vecs[v].o2, vecs[v].len, 0);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_all_sent", v), exp_q.size(), 0);
            check($sformatf("vec%0d_grant_released", v), grant, 0);
        end

        // Fairness: requester 0 has two messages queued back to back, 1 waits.
        @(negedge clk_in);
        push_msg(0, 2, 0);
        push_msg(0, 2, 4);
        push_msg(1, 1, 0);
        expect_msg(0, 2, 0);
        expect_msg(1, 1, 0);
        expect_msg(0, 2, 4);
        wait_idle("fairness");
        check("fairness_all_sent", exp_q.size(), 0);

        // Backpressure: uart busy while the arbiter sits in START.
        @(negedge clk_in);
        uart_auto = 1'b0;
        @(posedge clk_in);
        #1 tx_busy = 1'b1;
        @(negedge clk_in);
        push_msg(2, 1, 0);
        expect_msg(2, 1, 0);
        cyc = 0;
        while (rq[2].size() != 0 && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        check("bp_byte_accepted", (cyc < 100), 1);
        s0 = starts_seen;
        repeat (5) begin
            @(negedge clk_in);
            check("bp_no_start", tx_start, 0);
            check("bp_no_ready", req_ready, 0);
        end
        @(posedge clk_in);
        #1 tx_busy = 1'b0;
        @(negedge clk_in);
        check("bp_start_on_release", tx_start, 1);
        @(posedge clk_in);
        #1 tx_busy = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 tx_busy = 1'b0;
        wait_idle("bp");
        check("bp_single_start", starts_seen - s0, 1);
        @(negedge clk_in);
        uart_auto = 1'b1;

        // Reset while the first byte of a 3-byte message is on the wire.
        @(negedge clk_in);
        push_msg(0, 3, 0);
        expect_msg(0, 3, 0);
        s0  = starts_seen;
        cyc = 0;
        while (starts_seen == s0 && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        check("rstmid_first_start", (cyc < 100), 1);
        repeat (2) @(negedge clk_in);
        #2 reset = 1'b0;
        rq[0].delete();
        exp_q.delete();
        #1;
        check("rstmid_grant", grant, 0);
        check("rstmid_grant_active", grant_active, 0);
        check("rstmid_tx_start", tx_start, 0);
        check("rstmid_req_ready", req_ready, 0);
        @(negedge clk_in);
        #2 reset = 1'b1;
        @(negedge clk_in);
        check("rstmid_uart_still_busy", tx_busy, 1);
        push_msg(1, 2, 0);
        expect_msg(1, 2, 0);
        wait_idle("rstmid");
        check("rstmid_all_sent", exp_q.size(), 0);

        // Requester 1 stalls after its first byte while requester 2 waits.
        @(negedge clk_in);
        rq[1].push_back({1'b0, byte_of(1, 0)});
        cyc = 0;
        while (grant != 3'b010 && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        check("stall_granted", grant, 3'b010);
        stall_cnt = 0;
        push_msg(2, 1, 0);
`ifdef DEBUG_TX_ARB_TIMEOUT_EN
        begin
            exp_t nl;
            expect_msg(1, 1, 0);
            nl.data = 8'h0A;
            nl.src  = 1;
            exp_q.push_back(nl);
            expect_msg(2, 1, 0);
        end
        wait_idle("timeout");
        check("timeout_all_sent", exp_q.size(), 0);
        check("timeout_pulse_count", pulses_seen, 1);
`else
        expect_msg(1, 2, 0);
        expect_msg(2, 1, 0);
        repeat (40) @(negedge clk_in);
        check("stall_grant_held", grant, 3'b010);
        check("stall_pending_bytes", exp_q.size(), 2);
        rq[1].push_back({1'b1, byte_of(1, 1)});
        wait_idle("stall");
        check("stall_all_sent", exp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
